// File: rtl/averager_pkg.sv
// ---------------------------------------------------------------------------
// averager_pkg
//   Shared types and arithmetic for the coherent averager.
//   - state_t   : controller states
//   - round_sat : round-half-up divide by 2^n, then clamp to a signed
//                 sample range of sw bits
// ---------------------------------------------------------------------------
package averager_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, COLLECT, DRAIN} state_t;

   localparam int WIDE = 64;

   // Works on a wide signed value so the +2^(n-1) rounding term can never
   // wrap, whatever the accumulator width is.
   function automatic logic signed [WIDE-1:0] round_sat(
      input logic signed [WIDE-1:0] sum,
      input logic [7:0]             n,
      input int                     sw
   );
      logic signed [WIDE-1:0] r;
      logic signed [WIDE-1:0] hi;
      logic signed [WIDE-1:0] lo;
      if (n == 8'd0) r = sum;
      else           r = (sum + (64'sd1 <<< (n - 8'd1))) >>> n;
      hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/coherent_averager_if.sv
// ---------------------------------------------------------------------------
// coherent_averager_if
//   AXI-Stream beat bundle used on both sides of the averager.
//   master : drives tvalid/tdata/tlast/tstrb, receives tready
//   slave  : receives tvalid/tdata/tlast/tstrb, drives tready
// ---------------------------------------------------------------------------
interface coherent_averager_if #(
   parameter int DW = 32
);
   logic            tvalid;
   logic            tready;
   logic [DW-1:0]   tdata;
   logic            tlast;
   logic [DW/8-1:0] tstrb;

   modport master (output tvalid, tdata, tlast, tstrb, input tready);
   modport slave  (input tvalid, tdata, tlast, tstrb, output tready);
endinterface

// File: rtl/averager_acc_ram.sv
// ---------------------------------------------------------------------------
// averager_acc_ram
//   Simple dual-port accumulator RAM, one clock, synchronous read.
//   Read data holds when i_re is low; a same-address read during a write
//   returns the old contents.
//   i_clk                   : clock
//   i_we / i_waddr / i_wdata : write port
//   i_re / i_raddr / o_rdata : read port (1-cycle latency)
// ---------------------------------------------------------------------------
module averager_acc_ram #(
   parameter int W     = 23,
   parameter int DEPTH = 768,
   parameter int AW    = 10
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/coherent_averager.sv
// ---------------------------------------------------------------------------
// coherent_averager
//   Sums 2^N trigger-aligned records of SAMPLES_PER_TRIGGER signed samples,
//   then streams the rounded, saturated mean record with AXIS backpressure.
//   s00_axis_aclk/aresetn : clock, async active-low reset
//   s00_axis (slave)      : ADC samples; tready tied high
//   m00_axis (master)     : mean samples, tlast on last of record
//   trigger_in            : record trigger, rising edge counts
//   enable                : rise arms (latches log2_avg), low aborts to IDLE
//   log2_avg              : N, clamped to MAX_LOG2_AVG
//   busy / overrun        : state != IDLE / sticky beat-dropped-in-DRAIN
// ---------------------------------------------------------------------------
module coherent_averager
   import averager_pkg::*;
#(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int SAMPLE_WIDTH           = 16,
   parameter int SAMPLES_PER_TRIGGER    = 768,
   parameter int MAX_LOG2_AVG           = 7
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_aresetn,
   coherent_averager_if.slave                  s00_axis,
   coherent_averager_if.master                 m00_axis,
   input  logic                                trigger_in,
   input  logic                                enable,
   input  logic [$clog2(MAX_LOG2_AVG+1)-1:0]   log2_avg,
   output logic                                busy,
   output logic                                overrun
);

   localparam int ACC_WIDTH = SAMPLE_WIDTH + MAX_LOG2_AVG;
   localparam int AW        = $clog2(SAMPLES_PER_TRIGGER);
   localparam int NW        = $clog2(MAX_LOG2_AVG + 1);
   localparam int PW        = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;
   localparam int MW        = C_M00_AXIS_TDATA_WIDTH;

   state_t                        r_state;
   logic                          r_en_q, r_trig_q, r_overrun;
   logic [NW-1:0]                 r_n;
   logic [PW-1:0]                 r_pass_cnt;
   logic [AW-1:0]                 r_samp_cnt, r_rd_cnt;
   logic                          r_rd_done;
   // write-back stage of the read-modify-write
   logic                          r_wb_vld, r_wb_first;
   logic [AW-1:0]                 r_wb_addr;
   logic signed [ACC_WIDTH-1:0]   r_wb_x;
   logic                          r_fwd_hit;
   logic signed [ACC_WIDTH-1:0]   r_fwd_data;
   // drain: s1 = RAM output slot, m = output register
   logic                          r_s1_vld, r_s1_last;
   logic                          r_m_vld, r_m_last;
   logic [MW-1:0]                 r_m_data;

   logic                          w_en_rise, w_trig_pulse, w_beat, w_pass_last;
   logic                          w_rd_issue, w_s1_adv, w_m_hs, w_re;
   logic [AW-1:0]                 w_raddr;
   logic [ACC_WIDTH-1:0]          w_ram_q;
   logic signed [ACC_WIDTH-1:0]   w_acc_old, w_wr_data, w_x;
   logic signed [SAMPLE_WIDTH-1:0] w_x_s, w_mean_s;
   logic signed [WIDE-1:0]        w_mean;
   logic                          w_unused;

   assign w_en_rise    = enable & ~r_en_q;
   assign w_trig_pulse = trigger_in & ~r_trig_q;
   assign w_beat       = (r_state == COLLECT) & s00_axis.tvalid;
   assign w_pass_last  = (r_pass_cnt == PW'((32'd1 << r_n) - 32'd1));
   assign w_x_s        = s00_axis.tdata[SAMPLE_WIDTH-1:0];
   assign w_x          = ACC_WIDTH'(w_x_s);

   // Drain: a read is issued only when its result has a slot next cycle,
   // so the RAM output register doubles as the skid entry.
   assign w_m_hs     = r_m_vld & m00_axis.tready;
   assign w_s1_adv   = r_s1_vld & (~r_m_vld | m00_axis.tready);
   assign w_rd_issue = (r_state == DRAIN) & enable & ~r_rd_done & (~r_s1_vld | w_s1_adv);

   assign w_re    = w_beat | w_rd_issue;
   assign w_raddr = w_beat ? r_samp_cnt : r_rd_cnt;

   // The RAM returns old data on a same-address collision; the forwarded
   // write-back value replaces it in that case.
   assign w_acc_old = r_fwd_hit ? r_fwd_data : $signed(w_ram_q);
   assign w_wr_data = r_wb_first ? r_wb_x : w_acc_old + r_wb_x;

   assign w_mean   = round_sat(WIDE'(w_acc_old), 8'(r_n), SAMPLE_WIDTH);
   assign w_mean_s = w_mean[SAMPLE_WIDTH-1:0];

   averager_acc_ram #(.W(ACC_WIDTH), .DEPTH(SAMPLES_PER_TRIGGER), .AW(AW)) u_ram (
      .i_clk   (s00_axis_aclk),
      .i_we    (r_wb_vld),
      .i_waddr (r_wb_addr),
      .i_wdata (w_wr_data),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_state    <= IDLE;
         r_en_q     <= 1'b0;
         r_trig_q   <= 1'b0;
         r_overrun  <= 1'b0;
         r_n        <= '0;
         r_pass_cnt <= '0;
         r_samp_cnt <= '0;
         r_rd_cnt   <= '0;
         r_rd_done  <= 1'b0;
         r_wb_vld   <= 1'b0;
         r_wb_first <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_x     <= '0;
         r_fwd_hit  <= 1'b0;
         r_fwd_data <= '0;
         r_s1_vld   <= 1'b0;
         r_s1_last  <= 1'b0;
         r_m_vld    <= 1'b0;
         r_m_last   <= 1'b0;
         r_m_data   <= '0;
      end else begin
         r_en_q   <= enable;
         r_trig_q <= trigger_in;

         r_wb_vld <= w_beat;
         if (w_beat) begin
            r_wb_addr  <= r_samp_cnt;
            r_wb_x     <= w_x;
            r_wb_first <= (r_pass_cnt == '0);
         end
         if (w_re) begin
            r_fwd_hit  <= r_wb_vld & (r_wb_addr == w_raddr);
            r_fwd_data <= w_wr_data;
         end

         if (!enable) begin
            r_state   <= IDLE;
            r_s1_vld  <= 1'b0;
            r_m_vld   <= 1'b0;
            r_m_last  <= 1'b0;
            r_rd_done <= 1'b0;
         end else begin
            case (r_state)
               IDLE: if (w_en_rise) begin
                  r_state    <= WAIT_TRIG;
                  r_n        <= (log2_avg > NW'(MAX_LOG2_AVG)) ? NW'(MAX_LOG2_AVG) : log2_avg;
                  r_pass_cnt <= '0;
                  r_overrun  <= 1'b0;
               end
               WAIT_TRIG: if (w_trig_pulse) begin
                  r_state    <= COLLECT;
                  r_samp_cnt <= '0;
               end
               COLLECT: if (w_beat) begin
                  r_samp_cnt <= r_samp_cnt + AW'(1);
                  if (r_samp_cnt == AW'(SAMPLES_PER_TRIGGER - 1)) begin
                     if (w_pass_last) begin
                        r_state   <= DRAIN;
                        r_rd_cnt  <= '0;
                        r_rd_done <= 1'b0;
                        r_s1_vld  <= 1'b0;
                     end else begin
                        r_pass_cnt <= r_pass_cnt + PW'(1);
                        r_state    <= WAIT_TRIG;
                     end
                  end
               end
               DRAIN: begin
                  if (s00_axis.tvalid) r_overrun <= 1'b1;
                  if (w_rd_issue) begin
                     r_rd_cnt  <= r_rd_cnt + AW'(1);
                     r_s1_last <= (r_rd_cnt == AW'(SAMPLES_PER_TRIGGER - 1));
                     if (r_rd_cnt == AW'(SAMPLES_PER_TRIGGER - 1)) r_rd_done <= 1'b1;
                  end
                  if (w_rd_issue)    r_s1_vld <= 1'b1;
                  else if (w_s1_adv) r_s1_vld <= 1'b0;
                  if (w_s1_adv) begin
                     r_m_vld  <= 1'b1;
                     r_m_last <= r_s1_last;
                     r_m_data <= MW'(w_mean_s);
                  end else if (w_m_hs) begin
                     r_m_vld  <= 1'b0;
                     r_m_last <= 1'b0;
                  end
                  if (w_m_hs & r_m_last) r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign s00_axis.tready = 1'b1;
   assign m00_axis.tvalid = r_m_vld;
   assign m00_axis.tdata  = r_m_data;
   assign m00_axis.tlast  = r_m_last;
   assign m00_axis.tstrb  = '1;
   assign busy            = (r_state != IDLE);
   assign overrun         = r_overrun;

   // tlast/tstrb and the upper data bits of the input bus carry nothing here
   assign w_unused = &{1'b0, s00_axis.tlast, s00_axis.tstrb, s00_axis.tdata};

endmodule

// File: tb/tb_coherent_averager.sv
module tb_coherent_averager;
   localparam int DW   = 32;
   localparam int SW   = 16;
   localparam int SPT  = 8;
   localparam int MAXN = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       trigger_in, enable;
   logic [2:0] log2_avg;
   logic       busy, overrun;
   int         n_err = 0;
   int         n_chk = 0;

   always #5 clk = ~clk;

   coherent_averager_if #(.DW(DW)) s_if ();
   coherent_averager_if #(.DW(DW)) m_if ();

   coherent_averager #(
      .C_S00_AXIS_TDATA_WIDTH (DW),
      .C_M00_AXIS_TDATA_WIDTH (DW),
      .SAMPLE_WIDTH           (SW),
      .SAMPLES_PER_TRIGGER    (SPT),
      .MAX_LOG2_AVG           (MAXN)
   ) dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .s00_axis         (s_if),
      .m00_axis         (m_if),
      .trigger_in       (trigger_in),
      .enable           (enable),
      .log2_avg         (log2_avg),
      .busy             (busy),
      .overrun          (overrun)
   );

   typedef struct {
      int n;      // log2_avg
      int nrec;   // records to send
      bit ramp;   // add sample index to every sample
      int a;      // offset on even records
      int b;      // offset on odd records
      int e;      // hand-computed mean offset
   } vec_t;

   vec_t tv[8];

   task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic arm(input int n);
      @(negedge clk); enable = 1'b0; log2_avg = 3'(n);
      @(negedge clk); enable = 1'b1;
   endtask

   task automatic send_rec(input int v[8], input bit glitch, input bit extra);
      @(negedge clk); trigger_in = 1'b1;
      for (int i = 0; i < SPT; i++) begin
         @(negedge clk);
         trigger_in  = glitch && (i == 1 || i == 3);
         s_if.tvalid = 1'b1;
         s_if.tdata  = 32'(v[i]);
      end
      @(negedge clk); trigger_in = 1'b0;
      if (extra) begin s_if.tdata = 32'd1000; @(negedge clk); end
      s_if.tvalid = 1'b0;
   endtask

   task automatic drain(input int ex[8], input bit rnd, input bit chk_lat);
      int k, cyc, lat;
      bit stalled;
      logic [DW-1:0] held;
      k = 0; cyc = 0; lat = 0; stalled = 1'b0; held = '0;
      m_if.tready = 1'b1;
      while (!m_if.tvalid && lat < 50) begin @(negedge clk); lat++; end
      if (chk_lat) chk("first_latency", lat, 2);
      while (k < SPT && cyc < 300) begin
         if (m_if.tvalid) begin
            if (stalled) chk("stall_hold", m_if.tdata, held);
            if (m_if.tready) begin
               chk("mean", $signed(m_if.tdata), ex[k]);
               chk("tlast", m_if.tlast, (k == SPT - 1));
               k++; stalled = 1'b0;
            end else begin
               stalled = 1'b1; held = m_if.tdata;
            end
         end else if (stalled) begin
            chk("tvalid_held", m_if.tvalid, 1);
            stalled = 1'b0;
         end
         @(negedge clk); cyc++;
         if (rnd) m_if.tready = 1'($urandom_range(0, 1));
      end
      chk("beats", k, SPT);
      if (!rnd) chk("cycles_per_record", cyc, SPT);
      chk("tvalid_after", m_if.tvalid, 0);
      chk("busy_after", busy, 0);
      m_if.tready = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int v[8];
      int ex[8];
      rst_n = 1'b0; enable = 1'b0; trigger_in = 1'b0; log2_avg = '0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tstrb = '1;
      m_if.tready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", m_if.tvalid, 0);
      chk("rst_tlast", m_if.tlast, 0);
      chk("rst_tdata", m_if.tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("tready_const", s_if.tready, 1);
      rst_n = 1'b1;

      // n, nrec, ramp, a, b, expected mean offset
      tv[0] = '{2, 4, 1, 0, 0, 0};             // ramp -> 0..7
      tv[1] = '{1, 2, 0, 32767, 32766, 32767}; // (65533+1)>>1
      tv[2] = '{1, 2, 0, -3, -2, -2};          // (-5+1)>>>1
      tv[3] = '{0, 1, 0, -5, -5, -5};          // N=0 passes sum
      tv[4] = '{2, 4, 0, 10, 11, 11};          // 10.5 rounds up
      tv[5] = '{2, 4, 0, -10, -11, -10};       // -10.5 rounds up
      tv[6] = '{3, 8, 1, 1, 2, 2};             // ramp + 1.5 -> i+2
      tv[7] = '{1, 2, 0, -32768, -32768, -32768};

      for (int t = 0; t < 8; t++) begin
         arm(tv[t].n);
         for (int r = 0; r < tv[t].nrec; r++) begin
            for (int i = 0; i < SPT; i++)
               v[i] = (tv[t].ramp ? i : 0) + ((r % 2 == 0) ? tv[t].a : tv[t].b);
            send_rec(v, 1'b0, 1'b0);
         end
         for (int i = 0; i < SPT; i++) ex[i] = (tv[t].ramp ? i : 0) + tv[t].e;
         drain(ex, 1'b0, 1'b1);
         chk("overrun_idle", overrun, 0);
      end

      // random backpressure during drain
      arm(2);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < SPT; i++) v[i] = 3 * i - 7;
         send_rec(v, 1'b0, 1'b0);
      end
      for (int i = 0; i < SPT; i++) ex[i] = 3 * i - 7;
      drain(ex, 1'b1, 1'b1);

      // trigger glitches in COLLECT ignored; beat during DRAIN dropped
      arm(1);
      for (int i = 0; i < SPT; i++) v[i] = 4;
      send_rec(v, 1'b1, 1'b0);
      for (int i = 0; i < SPT; i++) v[i] = 6;
      send_rec(v, 1'b1, 1'b1);
      chk("overrun_set", overrun, 1);
      for (int i = 0; i < SPT; i++) ex[i] = 5;
      drain(ex, 1'b0, 1'b0);
      chk("overrun_sticky", overrun, 1);
      @(negedge clk); enable = 1'b0;
      @(negedge clk); enable = 1'b1;
      @(negedge clk);
      chk("overrun_cleared", overrun, 0);
      chk("busy_armed", busy, 1);

      // enable low aborts a stalled drain
      arm(0);
      for (int i = 0; i < SPT; i++) v[i] = 7;
      send_rec(v, 1'b0, 1'b0);
      m_if.tready = 1'b0;
      for (int i = 0; i < 10 && !m_if.tvalid; i++) @(negedge clk);
      chk("abort_tvalid_pre", m_if.tvalid, 1);
      chk("abort_tdata_pre", $signed(m_if.tdata), 7);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_tvalid", m_if.tvalid, 0);
      chk("abort_tlast", m_if.tlast, 0);
      chk("abort_busy", busy, 0);
      m_if.tready = 1'b1;

      // async reset mid-COLLECT on pass 2, then a clean constant run
      arm(2);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < SPT; i++) v[i] = 50 + i;
         send_rec(v, 1'b0, 1'b0);
      end
      @(negedge clk); trigger_in = 1'b1;
      @(negedge clk); trigger_in = 1'b0; s_if.tvalid = 1'b1; s_if.tdata = 32'd5;
      repeat (3) @(negedge clk);
      chk("busy_pre_reset", busy, 1);
      rst_n = 1'b0; s_if.tvalid = 1'b0; enable = 1'b0;
      #1;
      chk("areset_busy", busy, 0);
      chk("areset_tvalid", m_if.tvalid, 0);
      chk("areset_tdata", m_if.tdata, 0);
      @(negedge clk); rst_n = 1'b1;
      arm(2);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < SPT; i++) v[i] = 100;
         send_rec(v, 1'b0, 1'b0);
      end
      for (int i = 0; i < SPT; i++) ex[i] = 100;
      drain(ex, 1'b0, 1'b1);

      // log2_avg above MAX_LOG2_AVG clamps to 16 records
      arm(MAXN + 3);
      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < SPT; i++) v[i] = r;
         send_rec(v, 1'b0, 1'b0);
      end
      repeat (4) @(negedge clk);
      chk("clamp_no_drain", m_if.tvalid, 0);
      chk("clamp_busy", busy, 1);
      for (int i = 0; i < SPT; i++) v[i] = 15;
      send_rec(v, 1'b0, 1'b0);
      for (int i = 0; i < SPT; i++) ex[i] = 8;   // (120+8)>>4
      drain(ex, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
